// File: rtl/tcam_pkg.sv
// tcam_pkg: shared types and constants for the TCAM match-encoder slice.
//   state_e         - encoder FSM states
//   TCAM_ROWS       - rows per tcam7x64 slice (match-vector width)
//   TCAM_SLICE_BITS - key bits covered by one slice
package tcam_pkg;

  localparam int TCAM_ROWS       = 64;
  localparam int TCAM_SLICE_BITS = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ENC  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/tcam_prio_enc.sv
// tcam_prio_enc: combinational priority encoder + popcount over one match vector.
//   vec  in   ROWS      AND-reduced row-match vector
//   hit  out  1         any row matched
//   addr out  ADDR_W    lowest set row index (row 0 wins); 0 when no hit
//   cnt  out  ADDR_W+1  number of set rows (0..ROWS)
module tcam_prio_enc
  import tcam_pkg::*;
#(
  parameter  int ROWS   = TCAM_ROWS,
  localparam int ADDR_W = $clog2(ROWS)
) (
  input  logic [ROWS-1:0]   vec,
  output logic              hit,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   cnt
);

  always_comb begin
    hit  = |vec;
    addr = '0;
    cnt  = '0;
    // Scan high to low so the last write left standing is the lowest row.
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (vec[i]) addr = ADDR_W'(i);
    end
    for (int i = 0; i < ROWS; i++) begin
      cnt = cnt + (ADDR_W + 1)'(vec[i]);
    end
  end

endmodule

// File: rtl/tcam_match_encoder.sv
// tcam_match_encoder: combines per-slice TCAM match vectors into one search result.
//   in_clk / in_rstn            clock, synchronous active-low reset
//   in_search_vld/out_search_rdy search request handshake (accepted in IDLE only)
//   in_rdata                    NUM_BLOCKS slice vectors, slice k = [k*ROWS +: ROWS]
//   out_csb                     active-low slice chip select, low in the accept cycle
//   out_vld / in_rdy            result handshake
//   out_match_hit/multi_hit/addr/cnt  registered result, held until the next result
module tcam_match_encoder
  import tcam_pkg::*;
#(
  parameter  int NUM_BLOCKS = 4,
  parameter  int ROWS       = TCAM_ROWS,
  parameter  int RD_LATENCY = 1,
  localparam int ADDR_W     = $clog2(ROWS)
) (
  input  logic                       in_clk,
  input  logic                       in_rstn,
  input  logic                       in_search_vld,
  output logic                       out_search_rdy,
  input  logic [NUM_BLOCKS*ROWS-1:0] in_rdata,
  output logic                       out_csb,
  output logic                       out_vld,
  input  logic                       in_rdy,
  output logic                       out_match_hit,
  output logic                       out_multi_hit,
  output logic [ADDR_W-1:0]          out_match_addr,
  output logic [ADDR_W:0]            out_match_cnt
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e                           state, state_nxt;
  logic   [CNT_W-1:0]               wait_cnt;
  logic   [ROWS-1:0]                match_vec;
  logic   [NUM_BLOCKS:0][ROWS-1:0]  and_chain;
  logic                             accept;
  logic                             enc_hit;
  logic   [ADDR_W-1:0]              enc_addr;
  logic   [ADDR_W:0]                enc_cnt;

  // A row survives only if every key slice matched it.
  assign and_chain[0] = '1;
  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_and
    assign and_chain[k+1] = and_chain[k] & in_rdata[k*ROWS +: ROWS];
  end

  assign accept = (state == IDLE) && in_search_vld;

  tcam_prio_enc #(.ROWS(ROWS)) u_enc (
    .vec  (match_vec),
    .hit  (enc_hit),
    .addr (enc_addr),
    .cnt  (enc_cnt)
  );

  // State register
  always_ff @(posedge in_clk) begin
    if (!in_rstn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_search_vld)     state_nxt = WAIT;
      WAIT: if (wait_cnt == '0)    state_nxt = ENC;
      ENC:                         state_nxt = DONE;
      DONE: if (in_rdy)            state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Wait counter, captured vector and result registers
  always_ff @(posedge in_clk) begin
    if (!in_rstn) begin
      wait_cnt       <= '0;
      match_vec      <= '0;
      out_match_hit  <= 1'b0;
      out_multi_hit  <= 1'b0;
      out_match_addr <= '0;
      out_match_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) wait_cnt <= CNT_W'(RD_LATENCY - 1);
        WAIT: begin
          if (wait_cnt != '0) wait_cnt  <= wait_cnt - 1'b1;
          else                match_vec <= and_chain[NUM_BLOCKS];
        end
        ENC: begin
          out_match_hit  <= enc_hit;
          out_multi_hit  <= enc_cnt > (ADDR_W + 1)'(1);
          out_match_addr <= enc_addr;
          out_match_cnt  <= enc_cnt;
        end
        default: ;
      endcase
    end
  end

  // Outputs; chip select is gated by reset so a held request never strobes the slices.
  always_comb begin
    out_search_rdy = (state == IDLE);
    out_vld        = (state == DONE);
    out_csb        = !(accept && in_rstn);
  end

endmodule

// File: tb/tb_tcam_match_encoder.sv
module tb_tcam_match_encoder;
  import tcam_pkg::*;

  localparam int NB = 4;
  localparam int ROWS = 64;
  localparam int AW = 6;
  localparam int KW = NB * ROWS;

  typedef struct {
    logic          hit;
    logic          multi;
    logic [AW-1:0] addr;
    logic [AW:0]   cnt;
  } res_t;

  typedef struct {
    logic [KW-1:0] rd;
    res_t          exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: RD_LATENCY=1
  logic          a_rstn, a_svld, a_srdy, a_csb, a_vld, a_rdy, a_hit, a_multi;
  logic [KW-1:0] a_rdata;
  logic [AW-1:0] a_addr;
  logic [AW:0]   a_cnt;
  // DUT B: RD_LATENCY=3
  logic          b_rstn, b_svld, b_srdy, b_csb, b_vld, b_rdy, b_hit, b_multi;
  logic [KW-1:0] b_rdata;
  logic [AW-1:0] b_addr;
  logic [AW:0]   b_cnt;

  tcam_match_encoder #(.NUM_BLOCKS(NB), .ROWS(ROWS), .RD_LATENCY(1)) dut_a (
    .in_clk(clk), .in_rstn(a_rstn), .in_search_vld(a_svld), .out_search_rdy(a_srdy),
    .in_rdata(a_rdata), .out_csb(a_csb), .out_vld(a_vld), .in_rdy(a_rdy),
    .out_match_hit(a_hit), .out_multi_hit(a_multi), .out_match_addr(a_addr),
    .out_match_cnt(a_cnt));

  tcam_match_encoder #(.NUM_BLOCKS(NB), .ROWS(ROWS), .RD_LATENCY(3)) dut_b (
    .in_clk(clk), .in_rstn(b_rstn), .in_search_vld(b_svld), .out_search_rdy(b_srdy),
    .in_rdata(b_rdata), .out_csb(b_csb), .out_vld(b_vld), .in_rdy(b_rdy),
    .out_match_hit(b_hit), .out_multi_hit(b_multi), .out_match_addr(b_addr),
    .out_match_cnt(b_cnt));

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t sb[$];
  vec_t tv[7];

  function automatic res_t mk(input logic h, input logic m, input int a, input int c);
    res_t r;
    r.hit = h; r.multi = m; r.addr = AW'(a); r.cnt = (AW + 1)'(c);
    return r;
  endfunction

  function automatic logic [KW-1:0] pack4(input logic [63:0] s0, input logic [63:0] s1,
                                          input logic [63:0] s2, input logic [63:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string nm, input logic h, input logic m,
                         input logic [AW-1:0] a, input logic [AW:0] c, input res_t e);
    chk({nm, "_hit"},   64'(h), 64'(e.hit));
    chk({nm, "_multi"}, 64'(m), 64'(e.multi));
    chk({nm, "_addr"},  64'(a), 64'(e.addr));
    chk({nm, "_cnt"},   64'(c), 64'(e.cnt));
  endtask

  // Scoreboard for DUT A: compare on every completed result handshake.
  always @(negedge clk) begin : mon_a
    res_t e;
    if (a_vld === 1'b1 && a_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected: result addr=%0d with empty queue (t=%0t)", a_addr, $time);
      end else begin
        e = sb.pop_front();
        chk_res("sb", a_hit, a_multi, a_addr, a_cnt, e);
      end
    end
  end

  // Called just after a posedge with A in IDLE; returns on the negedge where out_vld is first seen.
  task automatic a_search(input logic [KW-1:0] rd, input res_t e);
    int k;
    a_rdata = rd; a_svld = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    chk("a_csb_accept", 64'(a_csb), 64'(0));
    chk("a_srdy_accept", 64'(a_srdy), 64'(1));
    k = 0;
    do begin
      @(posedge clk); #1; a_svld = 1'b0; k++;
      @(negedge clk);
    end while (a_vld !== 1'b1 && k < 20);
    chk("a_latency", 64'(k), 64'(3));
  endtask

  task automatic b_search(input logic [KW-1:0] rd, input res_t e);
    int k;
    b_rdata = rd; b_svld = 1'b1;
    @(negedge clk);
    chk("b_csb_accept", 64'(b_csb), 64'(0));
    k = 0;
    do begin
      @(posedge clk); #1; b_svld = 1'b0; k++;
      @(negedge clk);
    end while (b_vld !== 1'b1 && k < 20);
    chk("b_latency", 64'(k), 64'(5));
    chk_res("b_res", b_hit, b_multi, b_addr, b_cnt, e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] base;
    int          last, accepts;
    bit          seen;
    res_t        e;

    base = 64'h8000_0100_0000_0008;  // rows 63, 40, 3
    tv[0].rd = pack4(64'h100, 64'h100, 64'h100, 64'h100);          tv[0].exp = mk(1, 0, 8, 1);
    tv[1].rd = pack4(64'h20, 64'h20, 64'h20, 64'h0);               tv[1].exp = mk(0, 0, 0, 0);
    tv[2].rd = pack4(base | 64'h400, base | 64'h800, base | 64'h1, base | 64'h2);
    tv[2].exp = mk(1, 1, 3, 3);
    tv[3].rd = '1;                                                 tv[3].exp = mk(1, 1, 0, 64);
    tv[4].rd = '0;                                                 tv[4].exp = mk(0, 0, 0, 0);
    tv[5].rd = pack4({1'b1, 63'h0}, '1, {1'b1, 63'h1}, {2'b11, 62'h0});
    tv[5].exp = mk(1, 0, 63, 1);
    tv[6].rd = pack4(64'h3, 64'h7, 64'h2, 64'hF);                  tv[6].exp = mk(1, 0, 1, 1);

    a_rstn = 1'b0; a_svld = 1'b0; a_rdy = 1'b1; a_rdata = '0;
    b_rstn = 1'b0; b_svld = 1'b0; b_rdy = 1'b1; b_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld",  64'(a_vld),  64'(0));
    chk("rst_srdy", 64'(a_srdy), 64'(1));
    chk("rst_csb",  64'(a_csb),  64'(1));
    chk_res("rst", a_hit, a_multi, a_addr, a_cnt, mk(0, 0, 0, 0));
    @(posedge clk); #1;
    a_rstn = 1'b1; b_rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors, consumer always ready.
    for (int i = 0; i < 7; i++) begin
      a_search(tv[i].rd, tv[i].exp);
      @(posedge clk); #1;
    end

    // Backpressure: result must hold while in_rdy is low; requests are ignored.
    a_rdy = 1'b0;
    a_search(tv[2].rd, tv[2].exp);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a_svld = 1'b1;
      @(negedge clk);
      chk("bp_vld",  64'(a_vld),  64'(1));
      chk("bp_srdy", 64'(a_srdy), 64'(0));
      chk("bp_csb",  64'(a_csb),  64'(1));
      chk_res("bp_hold", a_hit, a_multi, a_addr, a_cnt, tv[2].exp);
    end
    @(posedge clk); #1;
    a_svld = 1'b0; a_rdy = 1'b1;
    @(negedge clk);
    chk("bp_srdy_hs", 64'(a_srdy), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_srdy_after", 64'(a_srdy), 64'(1));
    chk_res("idle_hold", a_hit, a_multi, a_addr, a_cnt, tv[2].exp);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_vld !== 1'b0) seen = 1'b1;
    end
    chk("bp_no_queued", 64'(seen), 64'(0));
    @(posedge clk); #1;

    // Back-to-back with request and ready held high.
    a_rdata = tv[0].rd; a_svld = 1'b1; last = -1; accepts = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (a_csb == 1'b0) begin
        sb.push_back(tv[0].exp);
        if (last >= 0) chk("b2b_spacing", 64'(c - last), 64'(4));
        last = c; accepts++;
      end
      @(posedge clk); #1;
    end
    a_svld = 1'b0;
    chk("b2b_accepts", 64'(accepts), 64'(6));
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'(0));

    // DUT B: a full search, then a reset during WAIT, then a clean search.
    @(posedge clk); #1;
    b_search(pack4(64'h60, 64'h20, 64'hE0, 64'h21), mk(1, 0, 5, 1));
    @(posedge clk); #1;
    b_rdata = tv[2].rd; b_svld = 1'b1;
    @(posedge clk); #1;
    b_svld = 1'b0;
    @(posedge clk); #1;
    b_rstn = 1'b0;
    @(posedge clk); #1;
    b_rstn = 1'b1;
    @(negedge clk);
    chk("b_rst_srdy", 64'(b_srdy), 64'(1));
    chk_res("b_rst", b_hit, b_multi, b_addr, b_cnt, mk(0, 0, 0, 0));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (b_vld !== 1'b0) seen = 1'b1;
    end
    chk("b_rst_no_vld", 64'(seen), 64'(0));
    @(posedge clk); #1;
    e = tv[3].exp;
    b_search(tv[3].rd, e);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_srdy_end", 64'(b_srdy), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
